// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board dimensions, cell colours and line-clear FSM states.
package tetris_pkg;
    typedef enum logic [2:0] {CL0, CL1, CL2, CL3, CL4, CL5, CL6, CL7} color_t;
    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int CELL_W = $bits(color_t);
    localparam int LINES_MAX = 999;
    typedef enum logic [2:0] {IDLE, READ, EVAL, FILL, DONE} lc_state_t;
endpackage

// File: rtl/row_full_detect.sv
// row_full_detect: flags a board row whose cells are all non-empty.
module row_full_detect #(
    parameter int COLS = 10,
    parameter int CW = 3
) (
    input  logic [COLS*CW-1:0] row,
    output logic               full
);
    always_comb begin
        full = 1'b1;
        for (int i = 0; i < COLS; i++) full &= |row[i*CW +: CW];
    end
endmodule

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: scans the board bottom-up, compacts surviving rows in place,
// zero-fills the vacated top rows and keeps the cleared-line counters.
module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS = BOARD_ROWS,
    parameter int COLS = BOARD_COLS,
    parameter int CW = CELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [4:0]         rd_addr,
    input  logic [COLS*CW-1:0] rd_data,
    output logic               wr_en,
    output logic [4:0]         wr_addr,
    output logic [COLS*CW-1:0] wr_data,
    output logic [4:0]         lines_cleared,
    output logic [9:0]         lines_total
);
    lc_state_t state, state_n;
    logic [4:0] rd, rd_n, wr, wr_n, k, k_n, wr_addr_n, lc_n;
    logic [COLS*CW-1:0] wr_data_n;
    logic [9:0] lt_n;
    logic [10:0] sum;
    logic wr_en_n, full;

    row_full_detect #(.COLS(COLS), .CW(CW)) u_full (.row(rd_data), .full(full));

    assign busy = state != IDLE;
    assign done = state == DONE;
    assign rd_addr = rd;
    assign sum = 11'(lines_total) + 11'(k);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rd <= '0;
            wr <= '0;
            k <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            lines_cleared <= '0;
            lines_total <= '0;
        end else begin
            state <= state_n;
            rd <= rd_n;
            wr <= wr_n;
            k <= k_n;
            wr_en <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            lines_cleared <= lc_n;
            lines_total <= lt_n;
        end
    end

    always_comb begin
        state_n = state;
        rd_n = rd;
        wr_n = wr;
        k_n = k;
        wr_en_n = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        lc_n = lines_cleared;
        lt_n = lines_total;
        case (state)
            IDLE: if (start) begin
                rd_n = 5'(ROWS - 1);
                wr_n = 5'(ROWS - 1);
                k_n = '0;
                state_n = READ;
            end
            READ: state_n = EVAL;
            EVAL: begin
                if (full) k_n = k + 5'd1;
                else begin
                    // wr == rd means the row is already in place
                    wr_en_n = wr != rd;
                    wr_addr_n = wr != rd ? wr : wr_addr;
                    wr_data_n = wr != rd ? rd_data : wr_data;
                    wr_n = wr - 5'd1;
                end
                if (rd == 5'd0) state_n = k_n != 5'd0 ? FILL : DONE;
                else begin
                    rd_n = rd - 5'd1;
                    state_n = READ;
                end
            end
            FILL: begin
                wr_en_n = 1'b1;
                wr_addr_n = wr;
                wr_data_n = '0;
                state_n = wr == 5'd0 ? DONE : FILL;
                wr_n = wr == 5'd0 ? wr : wr - 5'd1;
            end
            DONE: begin
                lc_n = k;
                lt_n = sum > 11'(LINES_MAX) ? 10'(LINES_MAX) : sum[9:0];
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: random and directed clear passes checked against a row-list model.
module tb_line_clear_ctrl;
    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int CW = 3;
    localparam int RW = COLS * CW;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic busy, done, wr_en;
    logic [4:0] rd_addr, wr_addr, lines_cleared;
    logic [RW-1:0] rd_data, wr_data;
    logic [9:0] lines_total;
    logic [RW-1:0] mem [ROWS];
    int total = 0, bad = 0, exp_total = 0;

    line_clear_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .lines_cleared(lines_cleared), .lines_total(lines_total)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_full(input logic [RW-1:0] row);
        for (int c = 0; c < COLS; c++) if (row[c*CW +: CW] == 0) return 0;
        return 1;
    endfunction

    function automatic logic [RW-1:0] gen_row(input int kind);
        logic [RW-1:0] r = '0;
        if (kind == 0) return r;
        for (int c = 0; c < COLS; c++)
            r[c*CW +: CW] = kind == 1 ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7));
        if (kind == 2) r[$urandom_range(0, COLS - 1)*CW +: CW] = '0;
        return r;
    endfunction

    task automatic run_pass(input bit again);
        logic [RW-1:0] exp_b [ROWS];
        int k = 0, copies = 0, d = ROWS - 1, dcyc = 0, ndone = 0, nwr = 0, brows = 0;
        for (int r = 0; r < ROWS; r++) exp_b[r] = '0;
        for (int r = ROWS - 1; r >= 0; r--)
            if (is_full(mem[r])) k++;
            else begin
                exp_b[d] = mem[r];
                if (d != r) copies++;
                d--;
            end
        exp_total = exp_total + k > 999 ? 999 : exp_total + k;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 2*ROWS + k + 60; i++) begin
            if (i == 1) check("busy_rise", busy, 1);
            if (again) start = i == 5;
            if (done) begin
                ndone++;
                if (dcyc == 0) dcyc = i;
            end
            if (wr_en) nwr++;
            if (dcyc != 0 && i == dcyc + 1) begin
                check("lines_cleared", lines_cleared, k);
                check("lines_total", lines_total, exp_total);
                check("busy_fall", busy, 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_cycle", dcyc, 2*ROWS + k + 1);
        check("done_pulses", ndone, 1);
        check("writes", nwr, k + copies);
        for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_b[r]) brows++;
        check("board_rows_bad", brows, 0);
    endtask

    task automatic load(input int kind0, input int kind1);
        for (int r = 0; r < ROWS; r++) mem[r] = gen_row($urandom_range(kind0, kind1));
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++) mem[r] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data == '0, 1);
        check("rst_lines_total", lines_total, 0);
        rst = 1'b1;
        @(negedge clk);
        // empty board
        run_pass(0);
        // bottom row full, single CL2 block above it
        mem[19] = gen_row(1);
        mem[18] = RW'(2);
        run_pass(0);
        check("row19_cl2", mem[19][2:0], 2);
        // two full rows interleaved with partial rows
        load(0, 0);
        mem[19] = gen_row(1);
        mem[17] = gen_row(1);
        mem[18] = gen_row(2);
        mem[16] = gen_row(2);
        run_pass(0);
        // start pulsed mid-pass must be ignored
        load(0, 2);
        run_pass(1);
        for (int n = 0; n < 8; n++) begin
            load(0, 2);
            run_pass(0);
        end
        // asynchronous reset mid-pass
        load(1, 2);
        start = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_total", lines_total, 0);
        exp_total = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load(0, 2);
        run_pass(0);
        // saturation: reset, then climb to exactly 998
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_total = 0;
        @(negedge clk);
        for (int n = 0; n < 49; n++) begin
            load(1, 1);
            run_pass(0);
        end
        load(1, 1);
        mem[0] = gen_row(2);
        mem[5] = gen_row(0);
        run_pass(0);
        check("total_998", lines_total, 998);
        load(0, 0);
        for (int r = 10; r < 14; r++) mem[r] = gen_row(1);
        run_pass(0);
        check("total_sat", lines_total, 999);
        load(1, 2);
        mem[19] = gen_row(1);
        run_pass(0);
        check("total_stays", lines_total, 999);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
